// File: rtl/commit_trace_buffer_if.sv
// Commit-record capture bus plus the oldest-first drain port of the trace buffer.
interface commit_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_insn;
  logic            cap_we;
  logic [4:0]      cap_rd;
  logic [XLEN-1:0] cap_wdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_insn;
  logic            out_we;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_wdata;

  modport slave (
    input  cap_valid, cap_pc, cap_insn, cap_we, cap_rd, cap_wdata, out_ready,
    output out_valid, out_pc, out_insn, out_we, out_rd, out_wdata
  );

  modport master (
    output cap_valid, cap_pc, cap_insn, cap_we, cap_rd, cap_wdata, out_ready,
    input  out_valid, out_pc, out_insn, out_we, out_rd, out_wdata
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Writeback commit trace buffer: stop-when-full or ring/trigger capture,
// then drains oldest-first over a valid/ready port.
module commit_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int MODE      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  commit_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     triggered,
  output logic                     overflow,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } rec_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, POST, DRAIN} state_t;

  state_t        state, state_nxt;
  rec_t          mem [DEPTH];
  rec_t          rec_in, rec_out;
  logic [AW-1:0] wptr, rptr, post_cnt;
  logic          clear, wr, pop, trig_hit, ovf_set, full;

  assign full   = (count == FULL_CNT);
  assign rec_in = '{pc: bus.cap_pc, insn: bus.cap_insn, we: bus.cap_we,
                    rd: bus.cap_rd, wdata: bus.cap_wdata};

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    wr        = 1'b0;
    pop       = 1'b0;
    trig_hit  = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE: if (arm) begin
        clear     = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (arm) clear = 1'b1;
        else begin
          wr       = bus.cap_valid;
          trig_hit = (MODE == 1) && trig_en && bus.cap_valid && (bus.cap_pc == trig_pc);
          ovf_set  = wr && full;
          if (stop)          state_nxt = DRAIN;
          else if (trig_hit) state_nxt = (POST_TRIG == 0) ? DRAIN : POST;
          else if ((MODE == 0) && wr && (count == FULL_CNT - 1'b1)) state_nxt = DRAIN;
        end
      end
      POST: begin
        wr      = bus.cap_valid;
        ovf_set = wr && full;
        if (stop || (wr && post_cnt == AW'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        pop = bus.out_valid && bus.out_ready;
        // Stop-when-full: late commits that arrive once full are lost records.
        ovf_set = (MODE == 0) && bus.cap_valid && full;
        if (count == '0 || (pop && count == (AW+1)'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
        // Ring mode: a write into a full store pushes out the oldest entry.
        if (full) rptr  <= rptr + 1'b1;
        else      count <= count + 1'b1;
      end
      if (pop) begin
        rptr  <= rptr + 1'b1;
        count <= count - 1'b1;
      end
      if (trig_hit) begin
        triggered <= 1'b1;
        post_cnt  <= POST_INIT;
      end else if (wr && state == POST) begin
        post_cnt <= post_cnt - 1'b1;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= rec_in;
  end

  assign rec_out       = mem[rptr];
  assign done          = (state == DRAIN);
  assign bus.out_valid = done && (count != '0);
  assign bus.out_pc    = rec_out.pc;
  assign bus.out_insn  = rec_out.insn;
  assign bus.out_we    = rec_out.we;
  assign bus.out_rd    = rec_out.rd;
  assign bus.out_wdata = rec_out.wdata;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboarded bench: a stop-when-full instance and a ring/trigger instance,
// both DEPTH 4, driven with directed commit sequences.
module tb_commit_trace_buffer;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic            arm0 = 0, stop0 = 0, trig_en0 = 0;
  logic            arm1 = 0, stop1 = 0, trig_en1 = 0;
  logic [XLEN-1:0] trig_pc0 = '0, trig_pc1 = '0;
  logic [2:0]      count0, count1;
  logic            triggered0, overflow0, done0;
  logic            triggered1, overflow1, done1;

  commit_trace_buffer_if #(.XLEN(XLEN)) bus0 ();
  commit_trace_buffer_if #(.XLEN(XLEN)) bus1 ();

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(4), .POST_TRIG(1), .MODE(0)) dut0 (
    .clock(clock), .reset(reset), .arm(arm0), .stop(stop0), .trig_en(trig_en0),
    .trig_pc(trig_pc0), .bus(bus0), .count(count0), .triggered(triggered0),
    .overflow(overflow0), .done(done0));

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(4), .POST_TRIG(1), .MODE(1)) dut1 (
    .clock(clock), .reset(reset), .arm(arm1), .stop(stop1), .trig_en(trig_en1),
    .trig_pc(trig_pc1), .bus(bus1), .count(count1), .triggered(triggered1),
    .overflow(overflow1), .done(done1));

  int   n_chk  = 0;
  int   n_fail = 0;
  rec_t q0[$], q1[$];
  rec_t e0, e1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic rec_t mk(input logic [31:0] pc);
    rec_t r;
    r.pc    = pc;
    r.insn  = {16'hC0DE, pc[15:0]};
    r.we    = 1'b1;
    r.rd    = pc[6:2];
    r.wdata = pc ^ 32'h5A5A_0000;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int sel, input rec_t r);
    if (sel == 0) begin
      bus0.cap_valid = 1'b1; bus0.cap_pc = r.pc; bus0.cap_insn = r.insn;
      bus0.cap_we = r.we; bus0.cap_rd = r.rd; bus0.cap_wdata = r.wdata;
    end else begin
      bus1.cap_valid = 1'b1; bus1.cap_pc = r.pc; bus1.cap_insn = r.insn;
      bus1.cap_we = r.we; bus1.cap_rd = r.rd; bus1.cap_wdata = r.wdata;
    end
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    if (sel == 0) bus0.out_ready = 1'b1; else bus1.out_ready = 1'b1;
    while (((sel == 0) ? done0 : done1) && n < 40) begin
      cyc();
      n++;
    end
    chk($sformatf("drain%0d_timeout", sel), 64'(n < 40), 64'(1));
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    chk($sformatf("drain%0d_queue_empty", sel), 64'((sel == 0) ? q0.size() : q1.size()), 64'(0));
  endtask

  // Monitors: every accepted beat is matched against the oldest queued expectation.
  always @(negedge clock) begin
    if (bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) chk("mon0_unexpected_pc", 64'(bus0.out_pc), 64'hFFFF_FFFF_FFFF);
      else begin
        e0 = q0.pop_front();
        chk("mon0_pc", 64'(bus0.out_pc), 64'(e0.pc));
        chk("mon0_insn", 64'(bus0.out_insn), 64'(e0.insn));
        chk("mon0_we", 64'(bus0.out_we), 64'(e0.we));
        chk("mon0_rd", 64'(bus0.out_rd), 64'(e0.rd));
        chk("mon0_wdata", 64'(bus0.out_wdata), 64'(e0.wdata));
      end
    end
  end

  always @(negedge clock) begin
    if (bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) chk("mon1_unexpected_pc", 64'(bus1.out_pc), 64'hFFFF_FFFF_FFFF);
      else begin
        e1 = q1.pop_front();
        chk("mon1_pc", 64'(bus1.out_pc), 64'(e1.pc));
        chk("mon1_insn", 64'(bus1.out_insn), 64'(e1.insn));
        chk("mon1_we", 64'(bus1.out_we), 64'(e1.we));
        chk("mon1_rd", 64'(bus1.out_rd), 64'(e1.rd));
        chk("mon1_wdata", 64'(bus1.out_wdata), 64'(e1.wdata));
      end
    end
  end

  initial begin
    rec_t r;
    bus0.cap_valid = 0; bus0.cap_pc = '0; bus0.cap_insn = '0; bus0.cap_we = 0;
    bus0.cap_rd = '0; bus0.cap_wdata = '0; bus0.out_ready = 0;
    bus1.cap_valid = 0; bus1.cap_pc = '0; bus1.cap_insn = '0; bus1.cap_we = 0;
    bus1.cap_rd = '0; bus1.cap_wdata = '0; bus1.out_ready = 0;

    repeat (2) cyc();
    chk("rst_count0", 64'(count0), 64'(0));
    chk("rst_valid0", 64'(bus0.out_valid), 64'(0));
    chk("rst_done0", 64'(done0), 64'(0));
    chk("rst_ovf0", 64'(overflow0), 64'(0));
    chk("rst_trig1", 64'(triggered1), 64'(0));
    reset = 1'b1;
    cyc();

    // Stop-when-full: 6 records, last two dropped, then backpressure and drain.
    arm0 = 1; cyc(); arm0 = 0;
    for (int i = 0; i < 6; i++) begin put(0, mk(32'h1000 + 4 * i)); cyc(); end
    bus0.cap_valid = 0;
    chk("full_count", 64'(count0), 64'(4));
    chk("full_done", 64'(done0), 64'(1));
    chk("full_overflow", 64'(overflow0), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_pc", 64'(bus0.out_pc), 64'h1000);
      chk("bp_count", 64'(count0), 64'(4));
      chk("bp_valid", 64'(bus0.out_valid), 64'(1));
    end
    for (int i = 0; i < 4; i++) q0.push_back(mk(32'h1000 + 4 * i));
    bus0.out_ready = 1;
    for (int i = 0; i < 4; i++) begin cyc(); chk("pop_count", 64'(count0), 64'(3 - i)); end
    chk("pop_idle_done", 64'(done0), 64'(0));
    chk("pop_idle_valid", 64'(bus0.out_valid), 64'(0));
    bus0.out_ready = 0;

    // Stop after two records.
    arm0 = 1; cyc(); arm0 = 0;
    put(0, mk(32'h2000)); cyc();
    put(0, mk(32'h2004)); cyc();
    bus0.cap_valid = 0; stop0 = 1; cyc(); stop0 = 0;
    chk("stop_count", 64'(count0), 64'(2));
    chk("stop_done", 64'(done0), 64'(1));
    chk("stop_overflow", 64'(overflow0), 64'(0));
    q0.push_back(mk(32'h2000)); q0.push_back(mk(32'h2004));
    drain(0);

    // Stop in the same cycle as a record: record kept.
    arm0 = 1; cyc(); arm0 = 0;
    put(0, mk(32'h3000)); cyc();
    put(0, mk(32'h3004)); stop0 = 1; cyc(); stop0 = 0; bus0.cap_valid = 0;
    chk("stopsame_count", 64'(count0), 64'(2));
    q0.push_back(mk(32'h3000)); q0.push_back(mk(32'h3004));
    drain(0);

    // Stop with nothing captured: DRAIN for one cycle then IDLE.
    arm0 = 1; cyc(); arm0 = 0;
    stop0 = 1; cyc(); stop0 = 0;
    chk("empty_done", 64'(done0), 64'(1));
    chk("empty_valid", 64'(bus0.out_valid), 64'(0));
    cyc();
    chk("empty_idle", 64'(done0), 64'(0));

    // Gapped commits with we=0 and distinct rd/wdata.
    arm0 = 1; cyc(); arm0 = 0;
    for (int i = 0; i < 4; i++) begin
      r.pc = 32'h5000 + 4 * i; r.insn = 32'h0000_0013 + 32'(i); r.we = 1'b0;
      r.rd = 5'(i + 3); r.wdata = 32'hDEAD_0000 + 32'(i);
      q0.push_back(r);
      put(0, r); cyc();
      bus0.cap_valid = 0; cyc(); cyc();
    end
    chk("gap_count", 64'(count0), 64'(4));
    chk("gap_overflow", 64'(overflow0), 64'(0));
    drain(0);

    // Ring mode with trigger at 0x1018, one post-trigger record.
    trig_en1 = 1; trig_pc1 = 32'h1018;
    arm1 = 1; cyc(); arm1 = 0;
    for (int i = 0; i < 9; i++) begin put(1, mk(32'h1000 + 4 * i)); cyc(); end
    bus1.cap_valid = 0;
    chk("ring_triggered", 64'(triggered1), 64'(1));
    chk("ring_overflow", 64'(overflow1), 64'(1));
    chk("ring_count", 64'(count1), 64'(4));
    chk("ring_done", 64'(done1), 64'(1));
    for (int i = 0; i < 4; i++) q1.push_back(mk(32'h1010 + 4 * i));
    drain(1);

    // Reset while in POST with three records held.
    trig_pc1 = 32'h4008;
    arm1 = 1; cyc(); arm1 = 0;
    for (int i = 0; i < 3; i++) begin put(1, mk(32'h4000 + 4 * i)); cyc(); end
    bus1.cap_valid = 0;
    chk("post_count", 64'(count1), 64'(3));
    chk("post_triggered", 64'(triggered1), 64'(1));
    chk("post_done", 64'(done1), 64'(0));
    reset = 0; cyc(); reset = 1;
    chk("rst_post_count", 64'(count1), 64'(0));
    chk("rst_post_valid", 64'(bus1.out_valid), 64'(0));
    chk("rst_post_trig", 64'(triggered1), 64'(0));
    chk("rst_post_done", 64'(done1), 64'(0));
    put(1, mk(32'h4010)); cyc(); bus1.cap_valid = 0;
    chk("idle_ignores_cap", 64'(count1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
